gauss3x3_conv: RTL and testbench

Consumer of the three-row column stream produced by `line_buffer`. It takes `top`/`mid`/`bot` plus `valid_in` and forms a 3x3 window with a column shift register. It applies the Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 with rounding and emits one filtered pixel per interior window. It sits directly after `line_buffer` in the Gaussian path and produces a valid-only (W-2)x(H-2) output image in raster order.

---
 rtl/gauss_pkg.sv | 44 ++++
 rtl/gauss3x3_conv_if.sv | 33 +++
 rtl/window3x3.sv | 82 ++++++++
 rtl/gauss3x3_conv.sv | 71 +++++++
 tb/tb_gauss3x3_conv.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/gauss_pkg.sv
// Shared types, kernel weights and arithmetic helpers for the 3x3 Gaussian filter.
package gauss_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned SUM_W    = 12;
    localparam int unsigned K_CORNER = 1;
    localparam int unsigned K_EDGE   = 2;
    localparam int unsigned K_CENTRE = 4;
    localparam int unsigned ROUND    = 8;
    localparam int unsigned SHIFT    = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [SUM_W-1:0] sum_t;
    // Window taps [row][col]; index 1 is the centre along both axes.
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    function automatic int unsigned tap_weight(input int i, input int j);
        if (i == 1 && j == 1) begin
            return K_CENTRE;
        end else if (i == 1 || j == 1) begin
            return K_EDGE;
        end
        return K_CORNER;
    endfunction

    // Full 12-bit accumulation: 255 * 16 = 4080 fits without truncation.
    function automatic sum_t kernel_sum(input win_t w);
        sum_t acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + sum_t'(w[i][j]) * sum_t'(tap_weight(i, j));
            end
        end
        return acc;
    endfunction

    function automatic pix_t round_pix(input sum_t s);
        sum_t t;
        t = s + sum_t'(ROUND);
        return pix_t'(t >> SHIFT);
    endfunction

endpackage

// File: rtl/gauss3x3_conv_if.sv
// Column stream in, filtered pixel stream out; no backpressure in either direction.
interface gauss3x3_conv_if;
    import gauss_pkg::*;

    pix_t top;
    pix_t mid;
    pix_t bot;
    logic valid_in;
    pix_t pixel_out;
    logic valid_out;
    logic last_out;

    modport slave (
        input  top,
        input  mid,
        input  bot,
        input  valid_in,
        output pixel_out,
        output valid_out,
        output last_out
    );

    modport master (
        output top,
        output mid,
        output bot,
        output valid_in,
        input  pixel_out,
        input  valid_out,
        input  last_out
    );

endinterface

// File: rtl/window3x3.sv
// 3x3 window of column shift registers plus row/col position counters.
// Qualified/last flags are registered alongside the window they describe.
module window3x3
    import gauss_pkg::*;
#(
    parameter int unsigned W = 9,
    parameter int unsigned H = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  pix_t top_i,
    input  pix_t mid_i,
    input  pix_t bot_i,
    input  logic valid_i,
    output win_t win_o,
    output logic qual_o,
    output logic last_o
);

    localparam int unsigned ColW = $clog2(W);
    localparam int unsigned RowW = $clog2(H);

    logic [2:0][PIX_W-1:0] t_q, t_d;
    logic [2:0][PIX_W-1:0] m_q, m_d;
    logic [2:0][PIX_W-1:0] b_q, b_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  qual_q, qual_d;
    logic                  last_q, last_d;
    logic                  col_end;
    logic                  row_end;

    assign col_end = (col_q == ColW'(W - 1));
    assign row_end = (row_q == RowW'(H - 1));

    always_comb begin
        t_d    = t_q;
        m_d    = m_q;
        b_d    = b_q;
        col_d  = col_q;
        row_d  = row_q;
        // Flags use the position of the column being accepted, before increment.
        qual_d = valid_i && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
        last_d = valid_i && row_end && col_end;
        if (valid_i) begin
            t_d = {t_q[1:0], top_i};
            m_d = {m_q[1:0], mid_i};
            b_d = {b_q[1:0], bot_i};
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q    <= '0;
            m_q    <= '0;
            b_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            qual_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            m_q    <= m_d;
            b_q    <= b_d;
            col_q  <= col_d;
            row_q  <= row_d;
            qual_q <= qual_d;
            last_q <= last_d;
        end
    end

    assign win_o  = {t_q, m_q, b_q};
    assign qual_o = qual_q;
    assign last_o = last_q;

endmodule

// File: rtl/gauss3x3_conv.sv
// 3x3 Gaussian [1 2 1; 2 4 2; 1 2 1]/16 with rounding over a three-row column stream.
// Two registered stages after the window: weighted sum, then round-and-shift.
module gauss3x3_conv
    import gauss_pkg::*;
#(
    parameter int unsigned W = 9,
    parameter int unsigned H = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    gauss3x3_conv_if.slave  stream_io
);

    win_t win;
    logic qual;
    logic last;

    sum_t sum_q, sum_d;
    logic sum_vld_q, sum_vld_d;
    logic sum_last_q, sum_last_d;
    pix_t pix_q, pix_d;
    logic vout_q, vout_d;
    logic lout_q, lout_d;

    window3x3 #(
        .W (W),
        .H (H)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .top_i   (stream_io.top),
        .mid_i   (stream_io.mid),
        .bot_i   (stream_io.bot),
        .valid_i (stream_io.valid_in),
        .win_o   (win),
        .qual_o  (qual),
        .last_o  (last)
    );

    always_comb begin
        sum_d      = kernel_sum(win);
        sum_vld_d  = qual;
        sum_last_d = last;
        pix_d      = round_pix(sum_q);
        vout_d     = sum_vld_q;
        lout_d     = sum_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_last_q <= 1'b0;
            pix_q      <= '0;
            vout_q     <= 1'b0;
            lout_q     <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
            sum_last_q <= sum_last_d;
            pix_q      <= pix_d;
            vout_q     <= vout_d;
            lout_q     <= lout_d;
        end
    end

    assign stream_io.pixel_out = pix_q;
    assign stream_io.valid_out = vout_q;
    assign stream_io.last_out  = lout_q;

endmodule

// File: tb/tb_gauss3x3_conv.sv
// Randomized bench for gauss3x3_conv: frames are fed as line_buffer-style columns and every
// output is scored against a direct image-domain convolution with exact arrival cycle.
module tb_gauss3x3_conv;

    localparam int W = 9;
    localparam int H = 6;

    typedef struct {
        logic [7:0] pix;
        logic       last;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    int   n_last = 0;
    int   img [H][W];
    exp_t sb [$];

    gauss3x3_conv_if vif ();

    gauss3x3_conv #(
        .W (W),
        .H (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stream_io (vif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: centre (r-1, c-1), weights (2-|dr|)*(2-|dc|), rounded divide by 16.
    function automatic int exp_pix(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                s += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc))
                     * img[r - 1 + dr][c - 1 + dc];
            end
        end
        return (s + 8) / 16;
    endfunction

    task automatic fill(input int mode, input int v);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0: img[r][c] = v;
                    1: img[r][c] = r * 16 + c;
                    2: img[r][c] = (r == 2 && c == 2) ? 255 : 0;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vif.valid_in = 1'b0;
            vif.top = 8'($urandom);
            vif.mid = 8'($urandom);
            vif.bot = 8'($urandom);
        end
    endtask

    // Rows above the frame carry junk, as a line_buffer would present stale lines.
    task automatic drive_col(input int r, input int c);
        exp_t e;
        @(negedge clk);
        vif.valid_in = 1'b1;
        vif.top = (r >= 2) ? 8'(img[r - 2][c]) : 8'($urandom);
        vif.mid = (r >= 1) ? 8'(img[r - 1][c]) : 8'($urandom);
        vif.bot = 8'(img[r][c]);
        if (r >= 2 && c >= 2) begin
            e.pix  = 8'(exp_pix(r, c));
            e.last = (r == H - 1) && (c == W - 1);
            e.due  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic drive_frame(input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap == 1 && !(r == 0 && c == 0)) idle(1);
                if (gap == 2 && $urandom_range(2) == 0) idle(1);
                drive_col(r, c);
            end
        end
    endtask

    task automatic run_frames(input int nf, input int gap);
        n_out  = 0;
        n_last = 0;
        for (int f = 0; f < nf; f++) drive_frame(gap);
        idle(6);
        chk("out_count", n_out, (W - 2) * (H - 2) * nf);
        chk("last_count", n_last, nf);
        chk("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (vif.valid_out) begin
                n_out++;
                if (vif.last_out) n_last++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", vif.pixel_out, e.pix);
                    chk("last", vif.last_out, e.last);
                    chk("latency_cycle", cyc, e.due);
                end
            end else begin
                if (vif.last_out) chk("last_without_valid", 1, 0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing_output", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.valid_in = 1'b0;
        vif.top = '0;
        vif.mid = '0;
        vif.bot = '0;
        repeat (3) @(negedge clk);
        chk("rst_pixel_out", vif.pixel_out, 0);
        chk("rst_valid_out", vif.valid_out, 0);
        chk("rst_last_out", vif.last_out, 0);
        rst_n = 1'b1;
        idle(2);

        fill(0, 100);
        run_frames(1, 0);
        fill(1, 0);
        run_frames(1, 0);
        fill(2, 0);
        run_frames(1, 0);
        fill(1, 0);
        run_frames(1, 1);
        fill(0, 255);
        run_frames(2, 0);
        fill(3, 0);
        run_frames(1, 2);

        // Reset in the middle of row 3 while outputs are in flight.
        fill(0, 100);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!(r == 3 && c > 4)) drive_col(r, c);
            end
        end
        @(posedge clk);
        #2;
        chk("pre_rst_valid", vif.valid_out, 1);
        chk("pre_rst_pixel", vif.pixel_out, 100);
        rst_n = 1'b0;
        vif.valid_in = 1'b0;
        #1;
        chk("async_rst_pixel", vif.pixel_out, 0);
        chk("async_rst_valid", vif.valid_out, 0);
        chk("async_rst_last", vif.last_out, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        fill(0, 50);
        run_frames(1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
